// File: rtl/uart_rx.sv
// uart_rx: receive side of the board UART (8N1, LSB first).
// The serial pin passes through a 2-flop synchroniser. The start bit is
// re-checked at mid-bit. Each data bit and the stop bit are then sampled
// once per bit period.
// A good frame gives a 1-cycle o_Rx_DV pulse. A stop bit that samples 0
// gives a 1-cycle o_Rx_Frame_Err pulse.
// Optional build macro UART_RX_MAJORITY_EN: each data/stop decision becomes
// the 2-of-3 majority of the synchronised line, taken at the last three
// counts of the bit period. Latency is the same as the single-sample build.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Busy,
  output logic       o_Rx_Frame_Err
);

  localparam logic [14:0] LAST_CNT = 15'(CLKS_PER_BIT - 1);
  localparam logic [14:0] HALF_CNT = 15'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      r_State;
  logic        r_Rx_Meta;
  logic        r_Rx;
  logic [14:0] r_Clock_Count;
  logic [2:0]  r_Bit_Index;
  logic [7:0]  r_Rx_Data;
  logic        w_Bit;

  // Two-flop synchroniser; both stages reset to the idle (high) level.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Rx_Meta <= 1'b1;
      r_Rx      <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx      <= r_Rx_Meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_Sample_Hist;
  logic [2:0] w_Samples;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Capture the line at counts LAST-2 and LAST-1 of each data/stop bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Sample_Hist <= 2'b11;
    end else if (((r_State == DATA) || (r_State == STOP)) &&
                 ((r_Clock_Count == (LAST_CNT - 15'd2)) ||
                  (r_Clock_Count == (LAST_CNT - 15'd1)))) begin
      r_Sample_Hist <= {r_Sample_Hist[0], r_Rx};
    end else begin
      r_Sample_Hist <= r_Sample_Hist;
    end
  end

  // Third vote is the line value at the decision count itself.
  assign w_Samples = {r_Sample_Hist, r_Rx};
  assign w_Bit     = maj3(w_Samples);
`else
  assign w_Bit = r_Rx;
`endif

  // Receive FSM; all outputs are registered here.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State        <= IDLE;
      r_Clock_Count  <= 15'd0;
      r_Bit_Index    <= 3'd0;
      r_Rx_Data      <= 8'h00;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Busy      <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      case (r_State)
        IDLE: begin
          r_Clock_Count <= 15'd0;
          r_Bit_Index   <= 3'd0;
          if (r_Rx == 1'b0) begin
            r_State   <= START;
            o_Rx_Busy <= 1'b1;
          end else begin
            o_Rx_Busy <= 1'b0;
          end
        end

        START: begin
          if (r_Clock_Count == HALF_CNT) begin
            r_Clock_Count <= 15'd0;
            if (r_Rx == 1'b0) begin
              r_State <= DATA;
            end else begin
              // Glitch, not a start bit.
              r_State   <= IDLE;
              o_Rx_Busy <= 1'b0;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + 15'd1;
          end
        end

        DATA: begin
          if (r_Clock_Count == LAST_CNT) begin
            r_Clock_Count          <= 15'd0;
            r_Rx_Data[r_Bit_Index] <= w_Bit;
            if (r_Bit_Index < 3'd7) begin
              r_Bit_Index <= r_Bit_Index + 3'd1;
            end else begin
              r_Bit_Index <= 3'd0;
              r_State     <= STOP;
            end
          end else begin
            r_Clock_Count <= r_Clock_Count + 15'd1;
          end
        end

        STOP: begin
          if (r_Clock_Count == LAST_CNT) begin
            r_Clock_Count <= 15'd0;
            if (w_Bit == 1'b1) begin
              o_Rx_Byte <= r_Rx_Data;
              o_Rx_DV   <= 1'b1;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
            end
            r_State <= CLEANUP;
          end else begin
            r_Clock_Count <= r_Clock_Count + 15'd1;
          end
        end

        CLEANUP: begin
          // A held-low line (break) parks here; no new frame starts until it rises.
          r_Clock_Count <= 15'd0;
          if (r_Rx == 1'b1) begin
            r_State   <= IDLE;
            o_Rx_Busy <= 1'b0;
          end else begin
            r_State <= CLEANUP;
          end
        end

        default: begin
          r_State       <= IDLE;
          r_Clock_Count <= 15'd0;
          r_Bit_Index   <= 3'd0;
          o_Rx_Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLKS_PER_BIT=16.
// Each frame is built as a per-clock waveform array. The reference decodes
// the byte by sampling that waveform at the mid-bit points, or by majority
// vote when UART_RX_MAJORITY_EN is defined. A negedge monitor records every
// DV/Err pulse with its cycle number.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int HALF  = (CPB - 1) / 2;
  localparam int FRAME = 10 * CPB;
  // The pin reaches the first flop at start+1. IDLE sees it two clocks later
  // (T0). The pulse is registered at T0+HALF+1+9*CPB.
  localparam int DV_LAT = 1 + 2 + HALF + 1 + 9 * CPB;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Rx_Serial = 1'b1;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Busy;
  logic       o_Rx_Frame_Err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int overlap = 0;
  int dv_cyc_q[$];
  logic [7:0] dv_byte_q[$];
  int err_cyc_q[$];
  logic wave [0:FRAME-1];
  logic busy_wave [0:FRAME-1];
  logic [7:0] exp_last = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock       (i_Clock),
    .i_Rst_n       (i_Rst_n),
    .i_Rx_Serial   (i_Rx_Serial),
    .o_Rx_DV       (o_Rx_DV),
    .o_Rx_Byte     (o_Rx_Byte),
    .o_Rx_Busy     (o_Rx_Busy),
    .o_Rx_Frame_Err(o_Rx_Frame_Err)
  );

  always #5 i_Clock = ~i_Clock;

  // Cycle counter used to time-stamp pulses.
  always @(posedge i_Clock) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge i_Clock) begin
    if (o_Rx_DV) begin
      dv_cyc_q.push_back(cyc);
      dv_byte_q.push_back(o_Rx_Byte);
    end
    if (o_Rx_Frame_Err) err_cyc_q.push_back(cyc);
    if (o_Rx_DV && o_Rx_Frame_Err) overlap <= overlap + 1;
  end

  task automatic clear_q();
    dv_cyc_q.delete();
    dv_byte_q.delete();
    err_cyc_q.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_Clock);
      i_Rx_Serial = 1'b1;
    end
  endtask

  // Build one 10-bit frame; gbit>=0 inverts the pin for one clock at offset goff of data bit gbit.
  task automatic build_wave(input logic [7:0] d, input logic stop_v, input int gbit, input int goff);
    for (int j = 0; j < FRAME; j++) begin
      int s;
      s = j / CPB;
      if (s == 0) wave[j] = 1'b0;
      else if (s <= 8) wave[j] = d[s-1];
      else wave[j] = stop_v;
    end
    if (gbit >= 0) wave[CPB*(gbit+1)+goff] = ~wave[CPB*(gbit+1)+goff];
  endtask

  task automatic drive_wave(input int nclk, output int start_cyc);
    start_cyc = 0;
    for (int j = 0; j < nclk; j++) begin
      @(negedge i_Clock);
      if (j == 0) start_cyc = cyc;
      busy_wave[j] = o_Rx_Busy;
      i_Rx_Serial = wave[j];
    end
  endtask

  // Reference decode: {stop, byte} from the waveform at the receiver's sample points.
  // Count c of a bit period lines up with pin offset c-(CPB-1)+HALF+1 in that bit.
  function automatic logic [8:0] decode();
    logic [8:0] r;
    r = 9'd0;
    for (int k = 0; k < 9; k++) begin
      int base;
      base = CPB * (k + 1) + HALF + 1;
`ifdef UART_RX_MAJORITY_EN
      r[k] = (int'(wave[base-2]) + int'(wave[base-1]) + int'(wave[base])) >= 2;
`else
      r[k] = wave[base];
`endif
    end
    return {r[8], r[7:0]};
  endfunction

  task automatic test_reset();
    i_Rst_n = 1'b0;
    i_Rx_Serial = 1'b1;
    repeat (3) @(negedge i_Clock);
    checks++; if (o_Rx_DV !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", o_Rx_DV); end
    checks++; if (o_Rx_Byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", o_Rx_Byte); end
    checks++; if (o_Rx_Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_Rx_Busy); end
    checks++; if (o_Rx_Frame_Err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", o_Rx_Frame_Err); end
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
    idle(6);
    checks++; if (o_Rx_Busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", o_Rx_Busy); end
    exp_last = 8'h00;
  endtask

  task automatic test_single();
    int s;
    logic [8:0] m;
    int bad;
    clear_q();
    build_wave(8'hA5, 1'b1, -1, 0);
    m = decode();
    drive_wave(FRAME, s);
    idle(4);
    checks++;
    if (dv_cyc_q.size() != 1) begin
      failures++; $display("FAIL single_dv_count got=%0d exp=1", dv_cyc_q.size());
    end else begin
      checks++; if (dv_byte_q[0] !== m[7:0]) begin failures++; $display("FAIL single_byte got=%h exp=%h", dv_byte_q[0], m[7:0]); end
      checks++; if (dv_cyc_q[0] != s + DV_LAT) begin failures++; $display("FAIL single_dv_time got=%0d exp=%0d", dv_cyc_q[0] - s, DV_LAT); end
    end
    checks++; if (err_cyc_q.size() != 0) begin failures++; $display("FAIL single_err_count got=%0d exp=0", err_cyc_q.size()); end
    checks++; if (o_Rx_Byte !== 8'hA5) begin failures++; $display("FAIL single_hold got=%h exp=a5", o_Rx_Byte); end
    bad = 0;
    for (int j = 0; j < 3; j++) if (busy_wave[j] !== 1'b0) bad++;
    for (int j = 3; j <= DV_LAT; j++) if (busy_wave[j] !== 1'b1) bad++;
    if (busy_wave[DV_LAT+2] !== 1'b0) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL single_busy got=%0d bad_cycles exp=0", bad); end
    exp_last = m[7:0];
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    logic [8:0] m1, m2;
    clear_q();
    build_wave(8'h00, 1'b1, -1, 0);
    m1 = decode();
    drive_wave(FRAME, s1);
    build_wave(8'hFF, 1'b1, -1, 0);
    m2 = decode();
    drive_wave(FRAME, s2);
    idle(4);
    checks++;
    if (dv_cyc_q.size() != 2) begin
      failures++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cyc_q.size());
    end else begin
      checks++; if (dv_byte_q[0] !== m1[7:0]) begin failures++; $display("FAIL b2b_byte0 got=%h exp=%h", dv_byte_q[0], m1[7:0]); end
      checks++; if (dv_byte_q[1] !== m2[7:0]) begin failures++; $display("FAIL b2b_byte1 got=%h exp=%h", dv_byte_q[1], m2[7:0]); end
      checks++; if (dv_cyc_q[1] - dv_cyc_q[0] != s2 - s1) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", dv_cyc_q[1] - dv_cyc_q[0], s2 - s1); end
      checks++; if (dv_cyc_q[1] != s2 + DV_LAT) begin failures++; $display("FAIL b2b_dv_time got=%0d exp=%0d", dv_cyc_q[1] - s2, DV_LAT); end
    end
    exp_last = m2[7:0];
  endtask

  task automatic test_false_start();
    clear_q();
    repeat (4) begin @(negedge i_Clock); i_Rx_Serial = 1'b0; end
    idle(24);
    checks++; if (dv_cyc_q.size() + err_cyc_q.size() != 0) begin failures++; $display("FAIL false_start_pulses got=%0d exp=0", dv_cyc_q.size() + err_cyc_q.size()); end
    checks++; if (o_Rx_Byte !== exp_last) begin failures++; $display("FAIL false_start_byte got=%h exp=%h", o_Rx_Byte, exp_last); end
    checks++; if (o_Rx_Busy !== 1'b0) begin failures++; $display("FAIL false_start_busy got=%b exp=0", o_Rx_Busy); end
  endtask

  task automatic test_frame_err();
    int s;
    logic [8:0] m;
    clear_q();
    build_wave(8'h3C, 1'b0, -1, 0);
    drive_wave(FRAME, s);
    repeat (40) begin @(negedge i_Clock); i_Rx_Serial = 1'b0; end
    checks++; if (o_Rx_Busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", o_Rx_Busy); end
    checks++;
    if (err_cyc_q.size() != 1) begin
      failures++; $display("FAIL ferr_count got=%0d exp=1", err_cyc_q.size());
    end else begin
      checks++; if (err_cyc_q[0] != s + DV_LAT) begin failures++; $display("FAIL ferr_time got=%0d exp=%0d", err_cyc_q[0] - s, DV_LAT); end
    end
    checks++; if (dv_cyc_q.size() != 0) begin failures++; $display("FAIL ferr_dv_count got=%0d exp=0", dv_cyc_q.size()); end
    checks++; if (o_Rx_Byte !== exp_last) begin failures++; $display("FAIL ferr_byte_hold got=%h exp=%h", o_Rx_Byte, exp_last); end
    idle(5);
    checks++; if (o_Rx_Busy !== 1'b0) begin failures++; $display("FAIL ferr_release_busy got=%b exp=0", o_Rx_Busy); end
    clear_q();
    build_wave(8'h11, 1'b1, -1, 0);
    m = decode();
    drive_wave(FRAME, s);
    idle(4);
    checks++;
    if (dv_byte_q.size() != 1) begin
      failures++; $display("FAIL ferr_next_count got=%0d exp=1", dv_byte_q.size());
    end else begin
      checks++; if (dv_byte_q[0] !== m[7:0]) begin failures++; $display("FAIL ferr_next_byte got=%h exp=%h", dv_byte_q[0], m[7:0]); end
    end
    exp_last = m[7:0];
  endtask

  task automatic test_reset_midframe();
    int s;
    logic [8:0] m;
    clear_q();
    build_wave(8'($urandom_range(255)), 1'b1, -1, 0);
    drive_wave(CPB * 4 + HALF, s);
    @(negedge i_Clock);
    i_Rst_n = 1'b0;
    i_Rx_Serial = 1'b1;
    #1;
    checks++; if ({o_Rx_DV, o_Rx_Busy, o_Rx_Frame_Err} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {o_Rx_DV, o_Rx_Busy, o_Rx_Frame_Err}); end
    checks++; if (o_Rx_Byte !== 8'h00) begin failures++; $display("FAIL midrst_byte got=%h exp=00", o_Rx_Byte); end
    repeat (2) @(negedge i_Clock);
    i_Rst_n = 1'b1;
    idle(FRAME);
    exp_last = 8'h00;
    checks++; if (dv_cyc_q.size() + err_cyc_q.size() != 0) begin failures++; $display("FAIL midrst_pulses got=%0d exp=0", dv_cyc_q.size() + err_cyc_q.size()); end
    build_wave(8'h5A, 1'b1, -1, 0);
    m = decode();
    drive_wave(FRAME, s);
    idle(4);
    checks++;
    if (dv_byte_q.size() != 1) begin
      failures++; $display("FAIL midrst_next_count got=%0d exp=1", dv_byte_q.size());
    end else begin
      checks++; if (dv_byte_q[0] !== m[7:0]) begin failures++; $display("FAIL midrst_next_byte got=%h exp=%h", dv_byte_q[0], m[7:0]); end
    end
    exp_last = m[7:0];
  endtask

  // One-clock low glitch on bit 2 of 0xFF, lined up with count 14 and then count 15.
  task automatic test_glitch();
    int s;
    logic [8:0] m;
    for (int c = CPB - 2; c <= CPB - 1; c++) begin
      clear_q();
      build_wave(8'hFF, 1'b1, 2, c - (CPB - 1) + HALF + 1);
      m = decode();
      drive_wave(FRAME, s);
      idle(4);
      checks++;
      if (dv_byte_q.size() != 1) begin
        failures++; $display("FAIL glitch_c%0d_count got=%0d exp=1", c, dv_byte_q.size());
      end else begin
        checks++; if (dv_byte_q[0] !== m[7:0]) begin failures++; $display("FAIL glitch_c%0d_byte got=%h exp=%h", c, dv_byte_q[0], m[7:0]); end
      end
      exp_last = m[7:0];
    end
  endtask

  task automatic test_random();
    int s;
    logic [8:0] m;
    logic [7:0] exp_q[$];
    int exp_cyc_q[$];
    clear_q();
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(1) == 1)
        build_wave(8'($urandom_range(255)), 1'b1, int'($urandom_range(7)), int'($urandom_range(CPB - 1)));
      else
        build_wave(8'($urandom_range(255)), 1'b1, -1, 0);
      m = decode();
      drive_wave(FRAME, s);
      exp_q.push_back(m[7:0]);
      exp_cyc_q.push_back(s + DV_LAT);
      idle(int'($urandom_range(3)));
    end
    idle(4);
    checks++;
    if (dv_byte_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", dv_byte_q.size(), exp_q.size());
    end else begin
      for (int n = 0; n < exp_q.size(); n++) begin
        checks++; if (dv_byte_q[n] !== exp_q[n]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", n, dv_byte_q[n], exp_q[n]); end
        checks++; if (dv_cyc_q[n] != exp_cyc_q[n]) begin failures++; $display("FAIL rand_time%0d got=%0d exp=%0d", n, dv_cyc_q[n], exp_cyc_q[n]); end
      end
    end
    checks++; if (err_cyc_q.size() != 0) begin failures++; $display("FAIL rand_err got=%0d exp=0", err_cyc_q.size()); end
    exp_last = exp_q[exp_q.size()-1];
    checks++; if (o_Rx_Byte !== exp_last) begin failures++; $display("FAIL rand_hold got=%h exp=%h", o_Rx_Byte, exp_last); end
  endtask

  task automatic test_exclusive();
    checks++; if (overlap != 0) begin failures++; $display("FAIL dv_err_overlap got=%0d exp=0", overlap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_midframe();
    test_glitch();
    test_random();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
